// File: rtl/seg7_display_ctrl_pkg.sv
// Shared constants for the seven-segment display peripheral: register
// offsets, CTRL bit positions and reset values.
package seg7_display_ctrl_pkg;

  typedef enum logic [1:0] {
    SEG_OFS_DATA = 2'd0,
    SEG_OFS_MASK = 2'd1,
    SEG_OFS_CTRL = 2'd2,
    SEG_OFS_RSVD = 2'd3
  } seg_ofs_e;

  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_DP_ALL_BIT = 1;

  localparam logic [31:0] DATA_RST = 32'h0000_0000;
  localparam logic [7:0]  MASK_RST = 8'hFF;
  localparam logic [1:0]  CTRL_RST = 2'b01;
  localparam logic [7:0]  OUT_OFF  = 8'hFF;

  // Select the hex nibble shown on digit idx (digit 0 is the low nibble).
  function automatic logic [3:0] digit_nibble(input logic [31:0] data, input logic [2:0] idx);
    logic [31:0] shifted;
    shifted = data >> {idx, 2'b00};
    return shifted[3:0];
  endfunction

endpackage

// File: rtl/seg7_display_ctrl_if.sv
// Peripheral-side CPU bus after bridge decode: select, word offset,
// write strobe/data and combinational readback.
interface seg7_display_ctrl_if;
  logic        sel;
  logic [11:0] addr;
  logic        wen;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output sel, output addr, output wen, output wdata, input rdata);
  modport slave  (input sel, input addr, input wen, input wdata, output rdata);
endinterface

// File: rtl/seg7_display_ctrl_hex_decoder.sv
// Nibble to seven-segment glyph, active-high {g,f,e,d,c,b,a}.
module seg7_hex_decoder (
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  // Standard 0-F glyph table.
  always_comb begin
    segs = 7'h00;
    case (nibble)
      4'h0: segs = 7'h3F;
      4'h1: segs = 7'h06;
      4'h2: segs = 7'h5B;
      4'h3: segs = 7'h4F;
      4'h4: segs = 7'h66;
      4'h5: segs = 7'h6D;
      4'h6: segs = 7'h7D;
      4'h7: segs = 7'h07;
      4'h8: segs = 7'h7F;
      4'h9: segs = 7'h6F;
      4'hA: segs = 7'h77;
      4'hB: segs = 7'h7C;
      4'hC: segs = 7'h39;
      4'hD: segs = 7'h5E;
      4'hE: segs = 7'h79;
      4'hF: segs = 7'h71;
      default: segs = 7'h00;
    endcase
  end

endmodule

// File: rtl/seg7_display_ctrl.sv
// Memory-mapped 8-digit seven-segment display controller: DATA/MASK/CTRL
// registers, combinational readback, and a blanked multiplexed scan.
import seg7_display_ctrl_pkg::*;

module seg7_display_ctrl #(
  parameter int unsigned SCAN_DIV     = 20000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic                 cpu_clk,
  input  logic                 cpu_rst,
  seg7_display_ctrl_if.slave   bus,
  output logic [7:0]           dig_en_n,
  output logic [7:0]           seg_n
);

  localparam int unsigned      CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);

  logic [31:0]      data_q, data_d;
  logic [7:0]       mask_q, mask_d;
  logic [1:0]       ctrl_q, ctrl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       dig_en_n_q, dig_en_n_d;
  logic [7:0]       seg_n_q, seg_n_d;

  logic [31:0]      rdata_s;
  logic             blank_s;
  logic [6:0]       hex_s;
  logic             unused_addr_s;

  seg_ofs_e ofs_s;
  assign ofs_s = seg_ofs_e'(bus.addr[3:2]);

  // Only the word-select bits of the offset matter.
  assign unused_addr_s = ^{bus.addr[11:4], bus.addr[1:0]};

  // Readback mux; reflects pre-write register contents in a write cycle.
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (bus.sel) begin
      case (ofs_s)
        SEG_OFS_DATA: rdata_s = data_q;
        SEG_OFS_MASK: rdata_s = {24'h00_0000, mask_q};
        SEG_OFS_CTRL: rdata_s = {30'h0000_0000, ctrl_q};
        default:      rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  assign bus.rdata = rdata_s;

  // Register write decode; the reserved offset swallows writes.
  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    ctrl_d = ctrl_q;
    if (bus.sel && bus.wen) begin
      case (ofs_s)
        SEG_OFS_DATA: data_d = bus.wdata;
        SEG_OFS_MASK: mask_d = bus.wdata[7:0];
        SEG_OFS_CTRL: ctrl_d = bus.wdata[1:0];
        default:      data_d = data_q;
      endcase
    end else begin
      data_d = data_q;
    end
  end

  // Slot prescaler and digit index; they free-run independent of EN.
  always_comb begin
    cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    idx_d = idx_q;
    if (cnt_q == CNT_MAX) begin
      cnt_d = {CNT_W{1'b0}};
      idx_d = idx_q + 3'd1;
    end else begin
      idx_d = idx_q;
    end
  end

  seg7_hex_decoder u_hex (
    .nibble (digit_nibble(data_q, idx_q)),
    .segs   (hex_s)
  );

  // Next output pattern: dark during the anti-ghosting window, when
  // disabled, or when the current digit is masked off.
  always_comb begin
    blank_s = ((BLANK_CYCLES != 0) && (cnt_q < BLANK_LIM))
              || !ctrl_q[CTRL_EN_BIT] || !mask_q[idx_q];
    if (blank_s) begin
      dig_en_n_d = OUT_OFF;
      seg_n_d    = OUT_OFF;
    end else begin
      dig_en_n_d = ~(8'h01 << idx_q);
      seg_n_d    = {~ctrl_q[CTRL_DP_ALL_BIT], ~hex_s};
    end
  end

  // State update; reset overrides a coincident bus write.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      data_q     <= DATA_RST;
      mask_q     <= MASK_RST;
      ctrl_q     <= CTRL_RST;
      cnt_q      <= {CNT_W{1'b0}};
      idx_q      <= 3'd0;
      dig_en_n_q <= OUT_OFF;
      seg_n_q    <= OUT_OFF;
    end else begin
      data_q     <= data_d;
      mask_q     <= mask_d;
      ctrl_q     <= ctrl_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      dig_en_n_q <= dig_en_n_d;
      seg_n_q    <= seg_n_d;
    end
  end

  assign dig_en_n = dig_en_n_q;
  assign seg_n    = seg_n_q;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Directed bench for seg7_display_ctrl with SCAN_DIV=4, BLANK_CYCLES=1.
module tb_seg7_display_ctrl;

  localparam int SD = 4;
  localparam int BC = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] dig_en_n;
  logic [7:0] seg_n;

  int passes = 0;
  int total  = 0;

  // Behavioural shadow of the register file and scan position.
  logic [31:0] m_data = 32'h0;
  logic [7:0]  m_mask = 8'hFF;
  logic [1:0]  m_ctrl = 2'b01;
  int          cyc    = 0;

  seg7_display_ctrl_if bus ();

  seg7_display_ctrl #(.SCAN_DIV(SD), .BLANK_CYCLES(BC)) dut (
    .cpu_clk  (clk),
    .cpu_rst  (rst),
    .bus      (bus),
    .dig_en_n (dig_en_n),
    .seg_n    (seg_n)
  );

  always #10 clk = ~clk;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic rd(input logic [1:0] ofs, input logic [31:0] exp);
    bus.sel  = 1'b1;
    bus.wen  = 1'b0;
    bus.addr = {8'h00, ofs, 2'b00};
    #1;
    check($sformatf("rdata_ofs%0d", ofs), bus.rdata, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      logic [7:0]  e_dig, e_seg;
      logic [31:0] sh;
      int          cnt, idx;
      cnt = cyc % SD;
      idx = (cyc / SD) % 8;
      if (rst || (cnt < BC) || !m_ctrl[0] || !m_mask[idx]) begin
        e_dig = 8'hFF;
        e_seg = 8'hFF;
      end else begin
        sh    = m_data >> (idx * 4);
        e_dig = ~(8'h01 << idx);
        e_seg = {~m_ctrl[1], ~glyph(sh[3:0])};
      end
      @(posedge clk);
      #1;
      if (rst) begin
        cyc    = 0;
        m_data = 32'h0;
        m_mask = 8'hFF;
        m_ctrl = 2'b01;
      end else begin
        cyc++;
        if (bus.sel && bus.wen) begin
          case (bus.addr[3:2])
            2'd0:    m_data = bus.wdata;
            2'd1:    m_mask = bus.wdata[7:0];
            2'd2:    m_ctrl = bus.wdata[1:0];
            default: ;
          endcase
        end
      end
      check($sformatf("dig_en_n@%0d", cyc), {24'h0, dig_en_n}, {24'h0, e_dig});
      check($sformatf("seg_n@%0d", cyc), {24'h0, seg_n}, {24'h0, e_seg});
    end
  endtask

  task automatic wr(input logic [1:0] ofs, input logic [31:0] val);
    bus.sel   = 1'b1;
    bus.wen   = 1'b1;
    bus.addr  = {8'h00, ofs, 2'b00};
    bus.wdata = val;
    tick(1);
    bus.wen   = 1'b0;
  endtask

  initial begin
    bus.sel   = 1'b0;
    bus.wen   = 1'b0;
    bus.addr  = 12'h000;
    bus.wdata = 32'h0;

    // Reset for two edges, outputs dark.
    rst = 1'b1;
    tick(2);
    rst = 1'b0;

    // Reset values of the register file.
    rd(2'd0, 32'h0000_0000);
    rd(2'd1, 32'h0000_00FF);
    rd(2'd2, 32'h0000_0001);
    rd(2'd3, 32'h0000_0000);

    // DATA write on the first post-reset edge; that edge still outputs dark.
    wr(2'd0, 32'h0123_4567);
    check("post_rst_dig", {24'h0, dig_en_n}, 32'h0000_00FF);
    tick(1);
    check("d0_seg", {24'h0, seg_n}, 32'h0000_00F8);
    check("d0_dig", {24'h0, dig_en_n}, 32'h0000_00FE);
    tick(28);
    check("d7_seg", {24'h0, seg_n}, 32'h0000_00C0);
    check("d7_dig", {24'h0, dig_en_n}, 32'h0000_007F);
    tick(4);
    check("wrap_dig", {24'h0, dig_en_n}, 32'h0000_00FE);
    tick(8);

    // Mask down to digits 0 and 2.
    wr(2'd1, 32'h0000_0005);
    tick(32);

    // Disable for a full frame, then enable with DP on every digit.
    wr(2'd2, 32'h0000_0000);
    tick(33);
    wr(2'd2, 32'h0000_0003);
    tick(32);
    rd(2'd2, 32'h0000_0003);

    // Reset beats a coincident DATA write; same-cycle read shows old value.
    bus.sel   = 1'b1;
    bus.wen   = 1'b1;
    bus.addr  = 12'h000;
    bus.wdata = 32'hDEAD_BEEF;
    rst       = 1'b1;
    #1;
    check("rd_during_rst_wr", bus.rdata, 32'h0123_4567);
    tick(1);
    rst = 1'b0;
    bus.wen = 1'b0;
    rd(2'd0, 32'h0000_0000);
    rd(2'd1, 32'h0000_00FF);
    rd(2'd2, 32'h0000_0001);

    // Ordinary write: readback in the write cycle is the old value.
    bus.sel   = 1'b1;
    bus.wen   = 1'b1;
    bus.addr  = 12'h000;
    bus.wdata = 32'hCAFE_F00D;
    #1;
    check("rd_during_wr", bus.rdata, 32'h0000_0000);
    tick(1);
    bus.wen = 1'b0;
    rd(2'd0, 32'hCAFE_F00D);
    tick(8);

    // Unselected write is ignored and rdata is zero.
    bus.sel   = 1'b0;
    bus.wen   = 1'b1;
    bus.addr  = 12'h000;
    bus.wdata = 32'h1111_1111;
    #1;
    check("rd_unsel", bus.rdata, 32'h0000_0000);
    tick(1);
    rd(2'd0, 32'hCAFE_F00D);

    // Reserved offset swallows writes and reads zero.
    bus.sel   = 1'b1;
    bus.wen   = 1'b1;
    bus.addr  = 12'h00C;
    bus.wdata = 32'hFFFF_FFFF;
    #1;
    check("rd_rsvd", bus.rdata, 32'h0000_0000);
    tick(1);
    rd(2'd0, 32'hCAFE_F00D);
    rd(2'd1, 32'h0000_00FF);
    rd(2'd2, 32'h0000_0001);
    rd(2'd3, 32'h0000_0000);
    bus.sel = 1'b0;
    tick(16);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
